spi_serf: RTL
=============

Name: spi_serf

Overview:
- SPI responder (serf) for the 16-bit, full-duplex SPI link driven by SPI_mnrch.
- Lets an on-chip block (sensor/ADC emulator, config register file) sit on the far end of the monarch bus.
- Captures each 16-bit MOSI command into a holding register with a ready flag.
- At the same time, shifts a preloaded 16-bit response out on MISO, MSB first.

Parameters:
- WIDTH, 16, frame length in bits; counter widths derive from it.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- SS_n  input  1  async serf select from monarch, active low, frames a transaction
- SCLK  input  1  async serial clock from monarch; idles high
- MOSI  input  1  async serial data from monarch
- MISO  output  1  serial data to monarch; high-Z while SS_n (synced) high
- tx_data  input  WIDTH  response word to send in the next frame
- wrt  input  1  one-cycle strobe: load tx_data into response buffer
- clr_cmd_rdy  input  1  consumer acknowledges cmd_rcvd
- cmd_rcvd  output  WIDTH  last complete command received
- cmd_rdy  output  1  cmd_rcvd holds a new, unacknowledged command
- frm_err  output  1  one-cycle pulse: frame ended with bit count != WIDTH
- busy  output  1  synced SS_n low (frame in progress)

Behaviour:
- Protocol: SPI mode 3 (CPOL=1, CPHA=1).
  - MISO changes after SCLK falls; MOSI is sampled on SCLK rise; MSB first.
  - SCLK high and low phases are each >= 4 clk periods; SPI_mnrch uses 16/16.
- Synchronisation:
  - SS_n, SCLK and MOSI each pass through 2 flops, plus a 3rd flop for edge detect on SS_n and SCLK.
  - Reset value of all sync flops is 1.
  - All decisions are made on synced signals.
- Arming: an armed flag is cleared by rst and set when synced SS_n is seen high. Edges are ignored while unarmed, so reset mid-frame drops the rest of that frame.
- Reset values:
  - MISO high-Z.
  - cmd_rcvd 0, cmd_rdy 0, frm_err 0, busy 0.
  - Response buffer 0, tx shift register 0, rx shift register 0, bit_cnt 0.
- Response buffer: wrt loads tx_data at any time, including mid-frame, with no effect on the frame in progress. With no wrt, the buffer persists and is resent.
- States: IDLE, SHIFT.
  - IDLE -> SHIFT on synced SS_n fall while armed: tx_shft <= buffer, bit_cnt <= 0, rx_shft kept.
  - SHIFT -> IDLE on synced SS_n rise.
- In SHIFT:
  - Synced SCLK rise: rx_shft <= {rx_shft[WIDTH-2:0], MOSI_sync}; bit_cnt++ saturating at WIDTH+1.
  - Synced SCLK fall with bit_cnt != 0: tx_shft <= tx_shft << 1. The first fall after SS_n falls launches the MSB and does not shift.
  - MISO = tx_shft[WIDTH-1].
- Frame end (SHIFT -> IDLE):
  - bit_cnt == WIDTH: cmd_rcvd <= rx_shft and cmd_rdy <= 1. A prior unacknowledged command is overwritten.
  - Any other bit_cnt (short frame, or more than WIDTH rises): cmd_rcvd unchanged, frm_err pulses 1 cycle.
- Latency: cmd_rdy / frm_err go high on the 3rd clk posedge after the raw SS_n rise is first sampled.
- cmd_rdy handshake:
  - Cleared by clr_cmd_rdy.
  - Set and clear in the same cycle: set wins.
  - Not cleared by a new frame start.
- Simultaneous SS_n rise and SCLK edge: the SS_n rise has priority; the SCLK edge is ignored.
- busy = ~SS_n_sync and armed.

Test Plan:
- Basic frame:
  - Stimulus: rst, wrt tx_data=16'h0C00, then SPI_mnrch sends cmd 16'h0800.
  - Required: MISO bits give resp 16'h0C00; cmd_rcvd=16'h0800, cmd_rdy=1 3 clks after SS_n rise; frm_err=0.
- Back-to-back and persistence:
  - Stimulus: no new wrt, send cmd 16'h2000.
  - Required: resp 16'h0C00 again; cmd_rcvd=16'h2000; cmd_rdy stays 1 until clr_cmd_rdy; in the same-cycle set+clr case cmd_rdy=1.
- Mid-frame wrt:
  - Stimulus: tx_data=16'hA5A5 loaded; wrt 16'h1234 after bit 5 of a frame.
  - Required: that frame returns 16'hA5A5; the next frame returns 16'h1234.
- Short frame:
  - Stimulus: SS_n low, 9 SCLK pulses, SS_n high.
  - Required: frm_err one-cycle pulse; cmd_rcvd and cmd_rdy unchanged.
- Long frame:
  - Stimulus: 17 SCLK pulses.
  - Required: frm_err pulse; cmd_rcvd unchanged.
- Reset mid-frame:
  - Stimulus: rst asserted after bit 8 and released while SS_n still low; remaining 8 pulses run; then a full frame with cmd 16'hFFFF.
  - Required: all outputs at reset values; no cmd_rdy or frm_err for the aborted frame; the next full frame gives cmd_rcvd=16'hFFFF and resp 16'h0000.

Source files
------------

// File: rtl/spi_serf.sv
// spi_serf: SPI mode-3 responder that captures MOSI commands and shifts a preloaded response out on MISO
module spi_serf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             wrt,
    input  logic             clr_cmd_rdy,
    output logic [WIDTH-1:0] cmd_rcvd,
    output logic             cmd_rdy,
    output logic             frm_err,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [CW-1:0] OVER = CW'(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [2:0]       ss_ff;
    logic [2:0]       sclk_ff;
    logic [1:0]       mosi_ff;
    logic [1:0]       settle;
    logic             armed;
    logic [WIDTH-1:0] buffer;
    logic [WIDTH-1:0] tx_shft;
    logic [WIDTH-1:0] rx_shft;
    logic [CW-1:0]    bit_cnt;
    logic             ss_sync;
    logic             ss_fall;
    logic             ss_rise;
    logic             sclk_rise;
    logic             sclk_fall;

    assign ss_sync   = ss_ff[1];
    assign ss_fall   = ss_ff[2] & ~ss_ff[1];
    assign ss_rise   = ~ss_ff[2] & ss_ff[1];
    assign sclk_rise = ~sclk_ff[2] & sclk_ff[1];
    assign sclk_fall = sclk_ff[2] & ~sclk_ff[1];
    assign busy      = ~ss_sync & armed;
    assign MISO      = busy ? tx_shft[WIDTH-1] : 1'bz;

    // Synchronise the SPI pins; arm only once the chain holds real samples, so a reset mid-frame cannot fake an SS_n fall
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_ff   <= '1;
            sclk_ff <= '1;
            mosi_ff <= '1;
            settle  <= '0;
            armed   <= 1'b0;
        end else begin
            ss_ff   <= {ss_ff[1:0], SS_n};
            sclk_ff <= {sclk_ff[1:0], SCLK};
            mosi_ff <= {mosi_ff[0], MOSI};
            settle  <= {settle[0], 1'b1};
            if (settle[1] && ss_sync) armed <= 1'b1;
        end
    end

    // Response buffer; a write during a frame only affects the next frame
    always_ff @(posedge clk) begin
        if (rst) buffer <= '0;
        else if (wrt) buffer <= tx_data;
    end

    // Frame FSM: shift on synced SCLK edges, judge the bit count when SS_n rises
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_shft  <= '0;
            rx_shft  <= '0;
            bit_cnt  <= '0;
            cmd_rcvd <= '0;
            cmd_rdy  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            if (clr_cmd_rdy) cmd_rdy <= 1'b0;
            if (state == IDLE) begin
                if (ss_fall && armed) begin
                    state   <= SHIFT;
                    tx_shft <= buffer;
                    bit_cnt <= '0;
                end
            end else if (ss_rise) begin
                state <= IDLE;
                if (bit_cnt == FULL) begin
                    cmd_rcvd <= rx_shft;
                    cmd_rdy  <= 1'b1;
                end else begin
                    frm_err <= 1'b1;
                end
            end else begin
                if (sclk_rise) begin
                    rx_shft <= {rx_shft[WIDTH-2:0], mosi_ff[1]};
                    if (bit_cnt != OVER) bit_cnt <= bit_cnt + 1'b1;
                end
                if (sclk_fall && bit_cnt != '0) tx_shft <= tx_shft << 1;
            end
        end
    end
endmodule
